// File: rtl/hps_fpga_pio_pkg.sv
// Shared definitions for the HPS-facing FIFO status PIO: register map,
// edge-capture mode encodings and the priming FSM states.
package hps_fpga_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
  localparam logic [1:0] ADDR_RESERVED = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Wide enough for the longest priming run (SYNC_STAGES = 4 -> 5 cycles).
  localparam int PRIME_CNT_W = 3;

  typedef enum logic {
    ST_PRIMING = 1'b0,
    ST_ARMED   = 1'b1
  } prime_state_e;

endpackage

// File: rtl/hps_fpga_fifo_status_in_if.sv
// Avalon-MM slave bus between the HPS bridge and the FIFO status PIO.
interface hps_fpga_fifo_status_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/hps_fpga_sync_chain.sv
// Per-bit flop chain that brings asynchronous status levels into the clk domain.
module hps_fpga_sync_chain #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/hps_fpga_fifo_status_in.sv
// FIFO status input PIO: synchronised level readback, sticky edge capture
// with write-1-to-clear, and a masked level interrupt to the HPS.
module hps_fpga_fifo_status_in
  import hps_fpga_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  hps_fpga_fifo_status_in_if.slave    avs,
  input  logic [WIDTH-1:0]            in_port,
  output logic                        irq
);

  localparam logic [PRIME_CNT_W-1:0] PRIME_LAST = PRIME_CNT_W'(SYNC_STAGES);

  logic [WIDTH-1:0]       syncData;
  logic [WIDTH-1:0]       prevData_q;
  logic [WIDTH-1:0]       irqMask_q, irqMask_d;
  logic [WIDTH-1:0]       edgeCap_q, edgeCap_d;
  logic [31:0]            readData_q, readData_d;
  logic [PRIME_CNT_W-1:0] primeCnt_q, primeCnt_d;
  prime_state_e           state_q, state_d;

  logic                   writeEn;
  logic [WIDTH-1:0]       writeBits;
  logic [WIDTH-1:0]       clearBits;
  logic [WIDTH-1:0]       rawEdges;
  logic [WIDTH-1:0]       edgeHits;
  logic                   unusedWriteBits;

  hps_fpga_sync_chain #(
    .DEPTH (SYNC_STAGES),
    .WIDTH (WIDTH)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (in_port),
    .q_o     (syncData)
  );

  assign unusedWriteBits = ^avs.writedata;

  // Levels sitting on in_port at reset must ripple through the chain and into
  // prevData_q before edges are believed, hence SYNC_STAGES+1 priming cycles.
  always_comb begin
    state_d    = state_q;
    primeCnt_d = primeCnt_q;
    case (state_q)
      ST_PRIMING: begin
        primeCnt_d = primeCnt_q + 1'b1;
        if (primeCnt_q == PRIME_LAST) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: primeCnt_d = primeCnt_q;
    endcase
  end

  always_comb begin
    rawEdges = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: rawEdges = ~syncData & prevData_q;
      EDGE_ANY:     rawEdges = syncData ^ prevData_q;
      default:      rawEdges = syncData & ~prevData_q;
    endcase
    edgeHits = (state_q == ST_ARMED) ? rawEdges : '0;
  end

  // A fresh edge is OR-ed in after the clear so it survives a same-cycle clear.
  always_comb begin
    writeEn   = avs.chipselect && !avs.write_n;
    writeBits = avs.writedata[WIDTH-1:0];
    clearBits = '0;
    irqMask_d = irqMask_q;
    if (writeEn && (avs.address == ADDR_IRQMASK)) begin
      irqMask_d = writeBits;
    end
    if (writeEn && (avs.address == ADDR_EDGECAP)) begin
      clearBits = writeBits;
    end
    edgeCap_d = (edgeCap_q & ~clearBits) | edgeHits;

    readData_d = '0;
    case (avs.address)
      ADDR_DATA:     readData_d = 32'(syncData);
      ADDR_IRQMASK:  readData_d = 32'(irqMask_q);
      ADDR_RESERVED: readData_d = '0;
      ADDR_EDGECAP:  readData_d = 32'(edgeCap_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_PRIMING;
      primeCnt_q <= '0;
      prevData_q <= '0;
      irqMask_q  <= '0;
      edgeCap_q  <= '0;
      readData_q <= '0;
    end else begin
      state_q    <= state_d;
      primeCnt_q <= primeCnt_d;
      prevData_q <= syncData;
      irqMask_q  <= irqMask_d;
      edgeCap_q  <= edgeCap_d;
      readData_q <= readData_d;
    end
  end

  assign avs.readdata = readData_q;
  assign irq          = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_hps_fpga_fifo_status_in.sv
// Bench for the FIFO status PIO: rising, falling and any-edge instances share
// stimulus and are checked against a cycle-level reference of the register map.
module tb_hps_fpga_fifo_status_in;
  import hps_fpga_pio_pkg::*;

  localparam int S = 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_port = 8'hFF;
  logic       irq0, irq1, irq2;
  bit         checkEn = 1'b0;
  int         assertions = 0;
  int         failures   = 0;

  hps_fpga_fifo_status_in_if bus0 ();
  hps_fpga_fifo_status_in_if bus1 ();
  hps_fpga_fifo_status_in_if bus2 ();

  hps_fpga_fifo_status_in #(.WIDTH(8), .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .reset_n(reset_n), .avs(bus0), .in_port(in_port), .irq(irq0));
  hps_fpga_fifo_status_in #(.WIDTH(8), .EDGE_TYPE(EDGE_FALLING), .SYNC_STAGES(S)) dut1 (
    .clk(clk), .reset_n(reset_n), .avs(bus1), .in_port(in_port), .irq(irq1));
  hps_fpga_fifo_status_in #(.WIDTH(8), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(S)) dut2 (
    .clk(clk), .reset_n(reset_n), .avs(bus2), .in_port(in_port), .irq(irq2));

  always #5 clk = ~clk;

  // Reference: a history of sampled inputs stands in for the synchroniser,
  // sync_data being the sample taken S clocks ago.
  logic [7:0]  hist[$];
  int          clocksSinceReset;
  logic [7:0]  mIrqMask;
  logic [7:0]  mCap[3];
  logic [31:0] mRd[3];
  logic [7:0]  mSync, mPrev, mWr8, mClr;
  bit          mWrEn, mArmed;

  function automatic logic [7:0] edgesFor(int e, logic [7:0] cur, logic [7:0] old);
    case (e)
      0:       return cur & ~old;
      1:       return ~cur & old;
      default: return cur ^ old;
    endcase
  endfunction

  task automatic modelReset();
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(8'h00);
    clocksSinceReset = 0;
    mIrqMask = 8'h00;
    for (int e = 0; e < 3; e++) begin
      mCap[e] = 8'h00;
      mRd[e]  = 32'h0;
    end
  endtask

  task automatic modelStep();
    mSync  = hist[S-1];
    mPrev  = hist[S];
    mWrEn  = bus0.chipselect && !bus0.write_n;
    mWr8   = bus0.writedata[7:0];
    mArmed = clocksSinceReset > S;
    mClr   = (mWrEn && bus0.address == 2'd3) ? mWr8 : 8'h00;
    for (int e = 0; e < 3; e++) begin
      case (bus0.address)
        2'd0:    mRd[e] = 32'(mSync);
        2'd1:    mRd[e] = 32'(mIrqMask);
        2'd3:    mRd[e] = 32'(mCap[e]);
        default: mRd[e] = 32'h0;
      endcase
      mCap[e] = (mCap[e] & ~mClr) | (mArmed ? edgesFor(e, mSync, mPrev) : 8'h00);
    end
    if (mWrEn && bus0.address == 2'd1) mIrqMask = mWr8;
    if (clocksSinceReset < 1000) clocksSinceReset++;
    hist.push_front(in_port);
    void'(hist.pop_back());
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) modelReset();
    else          modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model rd rising",  bus0.readdata, mRd[0]);
      checkOutput("model rd falling", bus1.readdata, mRd[1]);
      checkOutput("model rd any",     bus2.readdata, mRd[2]);
      checkOutput("model irq rising",  32'(irq0), 32'(|(mCap[0] & mIrqMask)));
      checkOutput("model irq falling", 32'(irq1), 32'(|(mCap[1] & mIrqMask)));
      checkOutput("model irq any",     32'(irq2), 32'(|(mCap[2] & mIrqMask)));
    end
  end

  task automatic driveBus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
    bus1.address = a; bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = wd;
    bus2.address = a; bus2.chipselect = cs; bus2.write_n = wn; bus2.writedata = wd;
  endtask

  task automatic busIdle();
    driveBus(2'd0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] wd);
    driveBus(a, 1'b1, 1'b0, wd);
    @(negedge clk);
    busIdle();
  endtask

  // Leaves readdata of all instances holding the value for address a.
  task automatic busRead(input logic [1:0] a);
    driveBus(a, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    busIdle();
  endtask

  task automatic doReset(input logic [7:0] level);
    @(negedge clk);
    #2 reset_n = 1'b0;
    in_port = level;
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(6);
  endtask

  typedef struct {
    logic [7:0]  inPort;
    bit          doWrite;
    logic [1:0]  wrAddr;
    logic [31:0] wrData;
    logic [1:0]  rdAddr;
    logic [31:0] expRd;
    logic        expIrq;
  } vec_t;

  vec_t vecs[12];

  // Each vector: settle in_port for 4 clocks, optional write, then read back on the rising instance.
  task automatic applyStimulus(input vec_t v, input int idx);
    in_port = v.inPort;
    waitCycles(4);
    if (v.doWrite) busWrite(v.wrAddr, v.wrData);
    busRead(v.rdAddr);
    checkOutput($sformatf("vec%0d readdata", idx), bus0.readdata, v.expRd);
    checkOutput($sformatf("vec%0d irq", idx), 32'(irq0), 32'(v.expIrq));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;

    vecs[0]  = '{8'h00, 1'b0, ADDR_DATA,     32'h0,        ADDR_DATA,     32'h00, 1'b0};
    vecs[1]  = '{8'h05, 1'b0, ADDR_DATA,     32'h0,        ADDR_EDGECAP,  32'h05, 1'b0};
    vecs[2]  = '{8'h05, 1'b1, ADDR_IRQMASK,  32'h04,       ADDR_IRQMASK,  32'h04, 1'b1};
    vecs[3]  = '{8'h05, 1'b1, ADDR_EDGECAP,  32'h04,       ADDR_EDGECAP,  32'h01, 1'b0};
    vecs[4]  = '{8'h00, 1'b0, ADDR_DATA,     32'h0,        ADDR_DATA,     32'h00, 1'b0};
    vecs[5]  = '{8'h00, 1'b1, ADDR_RESERVED, 32'hFF,       ADDR_RESERVED, 32'h00, 1'b0};
    vecs[6]  = '{8'h00, 1'b1, ADDR_IRQMASK,  32'hFF,       ADDR_IRQMASK,  32'hFF, 1'b1};
    vecs[7]  = '{8'h80, 1'b0, ADDR_DATA,     32'h0,        ADDR_EDGECAP,  32'h81, 1'b1};
    vecs[8]  = '{8'h80, 1'b1, ADDR_EDGECAP,  32'hFF,       ADDR_EDGECAP,  32'h00, 1'b0};
    vecs[9]  = '{8'h80, 1'b1, ADDR_EDGECAP,  32'h00,       ADDR_DATA,     32'h80, 1'b0};
    vecs[10] = '{8'h80, 1'b1, ADDR_IRQMASK,  32'hABCDEF12, ADDR_IRQMASK,  32'h12, 1'b0};
    vecs[11] = '{8'h13, 1'b0, ADDR_DATA,     32'h0,        ADDR_EDGECAP,  32'h13, 1'b1};

    busIdle();
    waitCycles(3);
    checkEn = 1'b1;
    checkOutput("reset rd rising", bus0.readdata, 32'h0);
    checkOutput("reset rd any",    bus2.readdata, 32'h0);
    checkOutput("reset irq any",   32'(irq2), 32'h0);

    // Inputs already high when reset releases must not look like edges.
    reset_n = 1'b1;
    waitCycles(10);
    busRead(ADDR_EDGECAP);
    checkOutput("prime edgecap rising",  bus0.readdata, 32'h0);
    checkOutput("prime edgecap falling", bus1.readdata, 32'h0);
    checkOutput("prime edgecap any",     bus2.readdata, 32'h0);
    checkOutput("prime irq rising", 32'(irq0), 32'h0);
    busRead(ADDR_DATA);
    checkOutput("prime data rising", bus0.readdata, 32'h000000FF);
    checkOutput("prime data any",    bus2.readdata, 32'h000000FF);

    doReset(8'h00);
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // Masked edge raises irq within the sync latency, cleared by W1C.
    doReset(8'h00);
    busWrite(ADDR_IRQMASK, 32'h05);
    in_port = 8'h01;
    got = 1'b0;
    for (int i = 0; i < S + 2 && !got; i++) begin
      @(negedge clk);
      if (irq0) got = 1'b1;
    end
    checkOutput("irq within bound", 32'(got), 32'h1);
    in_port = 8'h00;
    busRead(ADDR_EDGECAP);
    checkOutput("edgecap bit0", bus0.readdata, 32'h01);
    busWrite(ADDR_EDGECAP, 32'h01);
    checkOutput("irq after clear", 32'(irq0), 32'h0);

    // Clear lands on the very clock the second rising edge is captured.
    doReset(8'h00);
    in_port = 8'h04;
    waitCycles(4);
    busWrite(ADDR_EDGECAP, 32'h04);
    busRead(ADDR_EDGECAP);
    checkOutput("plain clear bit2", bus0.readdata, 32'h00);
    in_port = 8'h00;
    waitCycles(4);
    in_port = 8'h04;
    waitCycles(2);
    driveBus(ADDR_EDGECAP, 1'b1, 1'b0, 32'h04);
    waitCycles(1);
    busIdle();
    busRead(ADDR_EDGECAP);
    checkOutput("edge beats clear", bus0.readdata, 32'h04);

    // Unmasking an already captured bit.
    doReset(8'h00);
    in_port = 8'h80;
    waitCycles(4);
    checkOutput("masked irq low", 32'(irq0), 32'h0);
    busWrite(ADDR_IRQMASK, 32'h80);
    checkOutput("unmask irq high", 32'(irq0), 32'h1);
    busRead(ADDR_IRQMASK);
    checkOutput("irqmask readback", bus0.readdata, 32'h00000080);

    // Any-edge instance sees both transitions as separate captures.
    doReset(8'h00);
    in_port = 8'h08;
    waitCycles(4);
    busRead(ADDR_EDGECAP);
    checkOutput("any rise capture", bus2.readdata, 32'h08);
    busWrite(ADDR_EDGECAP, 32'h08);
    busRead(ADDR_EDGECAP);
    checkOutput("any cleared", bus2.readdata, 32'h00);
    in_port = 8'h00;
    waitCycles(4);
    busRead(ADDR_EDGECAP);
    checkOutput("any fall capture", bus2.readdata, 32'h08);
    busWrite(ADDR_RESERVED, 32'hFFFFFFFF);
    busRead(ADDR_RESERVED);
    checkOutput("reserved any",     bus2.readdata, 32'h0);
    checkOutput("reserved rising",  bus0.readdata, 32'h0);

    // Reset mid-operation wipes captured state at once.
    doReset(8'h00);
    in_port = 8'hFF;
    waitCycles(4);
    busWrite(ADDR_IRQMASK, 32'hFF);
    busRead(ADDR_EDGECAP);
    checkOutput("all bits captured", bus0.readdata, 32'hFF);
    checkOutput("irq before reset", 32'(irq0), 32'h1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async rd rising",  bus0.readdata, 32'h0);
    checkOutput("async rd any",     bus2.readdata, 32'h0);
    checkOutput("async irq rising", 32'(irq0), 32'h0);
    checkOutput("async irq any",    32'(irq2), 32'h0);
    waitCycles(3);
    reset_n = 1'b1;
    waitCycles(10);
    busRead(ADDR_EDGECAP);
    checkOutput("reprime rising", bus0.readdata, 32'h0);
    checkOutput("reprime any",    bus2.readdata, 32'h0);

    // Random traffic against the reference, with one reset in the middle.
    doReset(8'h00);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 300) #2 reset_n = 1'b0;
      if (i == 303) reset_n = 1'b1;
      if ($urandom_range(3) == 0) in_port = 8'($urandom);
      driveBus(2'($urandom_range(3)), 1'($urandom_range(1)),
               ($urandom_range(2) != 0), $urandom);
    end
    busIdle();
    waitCycles(2);

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/hps_fpga_fifo_status_in.md
HPS_FPGA_FIFO_STATUS_IN -- requirements
Module: hps_fpga_fifo_status_in

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, number of input status bits (1..32).
REQ-002 The block SHALL expose parameter EDGE_TYPE, default 0, capture mode: 0 rising, 1 falling, 2 any edge.
REQ-003 The block SHALL expose parameter SYNC_STAGES, default 2, synchronizer depth (2..4).
REQ-004 The block SHALL have port clk  input  1  system clock.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port address  input  2  Avalon-MM word address.
REQ-007 The block SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-008 The block SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-009 The block SHALL have port writedata  input  32  Avalon-MM write data.
REQ-010 The block SHALL have port in_port  input  WIDTH  asynchronous status inputs from FIFO logic.
REQ-011 The block SHALL have port readdata  output  32  Avalon-MM read data, zero-extended.
REQ-012 The block SHALL have port irq  output  1  level interrupt request, active-high.

Function
REQ-013 in_port SHALL pass through a SYNC_STAGES flop chain per bit; sync_data = last stage.
REQ-014 Register map SHALL be: addr 0 data (RO, sync_data), addr 1 irqmask (RW, WIDTH bits), addr 2 reserved (reads 0, writes ignored), addr 3 edgecapture (read; write-1-to-clear).
REQ-015 A write SHALL occur on a clk edge with chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
REQ-016 readdata SHALL be registered: value for the address presented in cycle N appears in cycle N+1 (read latency 1), updated every cycle regardless of chipselect.
REQ-017 Edge detect SHALL compare sync_data with its one-cycle-delayed copy prev_data; edge per EDGE_TYPE sets the matching edgecapture bit on the next clk edge.
REQ-018 edgecapture bits SHALL be sticky until cleared by writing 1 to that bit at addr 3; writing 0 leaves the bit unchanged.
REQ-019 Simultaneous edge and clear on the same bit in the same cycle: edge SHALL win; bit remains 1.
REQ-020 Priming: a counter SHALL count SYNC_STAGES+1 cycles after reset release; edge detection is suppressed until it saturates (state PRIMING -> ARMED, never returns except by reset), so input levels present at reset do not produce edges.
REQ-021 irq SHALL be the OR of (edgecapture AND irqmask), driven from registers (no combinational path from in_port or bus inputs).
REQ-022 Writing irqmask SHALL not alter edgecapture; unmasking a set bit asserts irq in the cycle after the write.
REQ-023 Input pulses shorter than one clk period are not guaranteed to be captured; pulses of >=2 clk periods SHALL always be captured in ARMED.

Reset
REQ-024 On reset_n=0 all synchronizer flops, prev_data, irqmask, edgecapture, readdata and the priming counter SHALL clear to 0 immediately; irq = 0.
REQ-025 Reset asserted mid-operation SHALL discard pending edges and re-enter PRIMING on release.

Structure
REQ-026 Register address constants (ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=3) and EDGE_TYPE encodings SHALL live in a shared package hps_fpga_pio_pkg.
REQ-027 The per-bit synchronizer SHALL be one sub-module, hps_fpga_sync_chain (parameterised depth and width); all other logic is flat in the top.

Verification
REQ-028 Reset, hold in_port=8'hFF through release, wait 10 cycles, read addr 3 -> readdata=0, irq=0; read addr 0 -> 32'h000000FF.
REQ-029 EDGE_TYPE=0, ARMED, irqmask=8'h05, drive in_port 0->8'h01 for 3 cycles -> edgecapture=8'h01 within SYNC_STAGES+2 cycles, irq=1; write 8'h01 to addr 3 -> irq=0 next cycle.
REQ-030 Rising edge on bit 2 in the same cycle as a clear of bit 2 -> edgecapture[2] stays 1.
REQ-031 edgecapture=8'h80, irqmask=0 -> irq=0; write irqmask=8'h80 -> irq=1 one cycle later; addr 1 reads 32'h00000080.
REQ-032 EDGE_TYPE=2, toggle bit 3 high then low (each held 4 cycles), clear between -> two separate captures observed; addr 2 always reads 0.
REQ-033 Assert reset_n=0 while edgecapture=8'hFF -> all outputs 0 immediately; after release no edges captured during PRIMING.
